// File: rtl/des_key_search_ctrl.sv
// Brute-force DES key-search sequencer: issues LANES keys per cycle, realigns the results with a
// tag pipe and latches the lowest matching key. Optional hit counter: DES_SEARCH_PERF_EN.
module des_key_search_ctrl #(
  parameter int unsigned LANES   = 28,
  parameter int unsigned KEY_W   = 56,
  parameter int unsigned LATENCY = 17
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  input  logic [LANES-1:0] match_vec,
  output logic [KEY_W-1:0] base_key,
  output logic             issue_valid,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] found_key
`ifdef DES_SEARCH_PERF_EN
  ,
  output logic [KEY_W:0]   keys_tested
`endif
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned KW1    = KEY_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [KEY_W-1:0]   r_base_key;
  logic               r_issue_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [KEY_W-1:0]   r_found_key;
  logic [KEY_W-1:0]   r_hi;
  logic [LATENCY-1:0] r_tag_v;
  logic [KEY_W-1:0]   r_tag_base [LATENCY];

  logic [LANES-1:0]   w_qual;
  logic [LANES-1:0]   w_hits;
  logic               w_hit;
  logic [LANE_W-1:0]  w_idx;
  logic               w_last;
  logic               w_upstream;

  // Lane qualification against the latched upper bound, then lowest-index priority pick
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_qual[i] = r_tag_v[LATENCY-1] &&
                  (({1'b0, r_tag_base[LATENCY-1]} + KW1'(i)) <= {1'b0, r_hi});
    end
    w_hits = w_qual & match_vec;
    w_hit  = |w_hits;
    w_idx  = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (w_hits[i]) w_idx = LANE_W'(i);
    end
  end

  // Widened compare so a range ending at the top of the key space does not wrap
  assign w_last = ({1'b0, r_base_key} + KW1'(LANES - 1)) >= {1'b0, r_hi};

  // Any tag still upstream of the retire stage means the pipe is not yet empty
  always_comb begin
    w_upstream = 1'b0;
    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
      w_upstream = w_upstream | r_tag_v[i];
    end
  end

`ifdef DES_SEARCH_PERF_EN
  logic [KEY_W:0] w_pop;
  logic [KEY_W:0] r_keys_tested;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_pop = w_pop + KW1'(w_qual[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_keys_tested <= '0;
    end else if (!abort && (r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_keys_tested <= '0;
    end else if (!abort && (r_state == S_RUN || r_state == S_DRAIN)) begin
      r_keys_tested <= r_keys_tested + w_pop;
    end
  end

  assign keys_tested = r_keys_tested;
`endif

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_base_key    <= '0;
      r_issue_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_key   <= '0;
      r_hi          <= '0;
      r_tag_v       <= '0;
      for (int i = 0; i < int'(LATENCY); i++) r_tag_base[i] <= '0;
    end else begin
      r_tag_v[0]    <= r_issue_valid;
      r_tag_base[0] <= r_base_key;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_base[i] <= r_tag_base[i-1];
      end

      if (abort) begin
        r_state       <= S_IDLE;
        r_base_key    <= '0;
        r_issue_valid <= 1'b0;
        r_busy        <= 1'b0;
        r_done        <= 1'b0;
        r_found       <= 1'b0;
        r_found_key   <= '0;
        r_tag_v       <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_hi        <= key_hi;
              r_found     <= 1'b0;
              r_found_key <= '0;
              if (key_lo > key_hi) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state       <= S_RUN;
                r_done        <= 1'b0;
                r_busy        <= 1'b1;
                r_base_key    <= key_lo;
                r_issue_valid <= 1'b1;
              end
            end
          end
          S_RUN, S_DRAIN: begin
            if (w_hit) begin
              // First qualified hit ends the search; in-flight tags are dropped
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_found       <= 1'b1;
              r_found_key   <= r_tag_base[LATENCY-1] + KEY_W'(w_idx);
              r_busy        <= 1'b0;
              r_issue_valid <= 1'b0;
              r_base_key    <= '0;
              r_tag_v       <= '0;
            end else if (r_state == S_RUN) begin
              if (w_last) begin
                r_state       <= S_DRAIN;
                r_issue_valid <= 1'b0;
                r_base_key    <= '0;
              end else begin
                r_base_key <= r_base_key + KEY_W'(LANES);
              end
            end else if (!w_upstream) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign base_key    = r_base_key;
  assign issue_valid = r_issue_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign found_key   = r_found_key;

endmodule

// File: tb/tb_des_key_search_ctrl.sv
// Directed bench for des_key_search_ctrl (LANES=28, LATENCY=17); cycle 0 is the start cycle.
module tb_des_key_search_ctrl;

  localparam int unsigned LANES = 28;
  localparam int unsigned KEY_W = 56;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [KEY_W-1:0] key_lo, key_hi;
  logic [LANES-1:0] match_vec;
  logic [KEY_W-1:0] base_key, found_key;
  logic             issue_valid, busy, done, found;
`ifdef DES_SEARCH_PERF_EN
  logic [KEY_W:0]   keys_tested;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [KEY_W-1:0] kmax;

  des_key_search_ctrl dut (
    .CLOCK_50(clk), .RESET(rst), .start(start), .abort(abort),
    .key_lo(key_lo), .key_hi(key_hi), .match_vec(match_vec),
    .base_key(base_key), .issue_valid(issue_valid), .busy(busy),
    .done(done), .found(found), .found_key(found_key)
`ifdef DES_SEARCH_PERF_EN
    , .keys_tested(keys_tested)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic go(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
    key_lo = lo;
    key_hi = hi;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chkk(input string tag, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chkk({tag, "_base"}, base_key, '0);
    chk1({tag, "_iv"}, issue_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_found"}, found, 1'b0);
    chkk({tag, "_fkey"}, found_key, '0);
  endtask

  initial begin
    kmax      = '1;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    key_lo    = '0;
    key_hi    = '0;
    match_vec = '0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // Match at lane 16 of base 84 -> key 100, reported at cycle 22
    go(56'd0, 56'd1000);
    chkk("t1_base_c1", base_key, 56'd0);
    chk1("t1_iv_c1", issue_valid, 1'b1);
    chk1("t1_busy_c1", busy, 1'b1);
    tick();
    chkk("t1_base_c2", base_key, 56'd28);
    run_to(21);
    chk1("t1_found_c21", found, 1'b0);
    match_vec = LANES'(1) << 16;
    tick();
    match_vec = '0;
    chk1("t1_found", found, 1'b1);
    chk1("t1_done", done, 1'b1);
    chkk("t1_fkey", found_key, 56'd100);
    chk1("t1_busy", busy, 1'b0);
    chk1("t1_iv", issue_valid, 1'b0);
    match_vec = '1;
    tick();
    match_vec = '0;
    chkk("t1_fkey_hold", found_key, 56'd100);

    // Restart from DONE; exhaustion after two issues
    go(56'd0, 56'd55);
    chk1("t2_done_clr", done, 1'b0);
    chk1("t2_found_clr", found, 1'b0);
    chkk("t2_fkey_clr", found_key, 56'd0);
    tick();
    chkk("t2_base_c2", base_key, 56'd28);
    chk1("t2_iv_c2", issue_valid, 1'b1);
    tick();
    chk1("t2_iv_c3", issue_valid, 1'b0);
    chk1("t2_busy_c3", busy, 1'b1);
    run_to(19);
    chk1("t2_done_c19", done, 1'b0);
    tick();
    chk1("t2_done_c20", done, 1'b1);
    chk1("t2_found_c20", found, 1'b0);
    chk1("t2_busy_c20", busy, 1'b0);

    // Lane 5 of base 28 is key 33 > hi=29: masked
    go(56'd0, 56'd29);
    run_to(19);
    match_vec = LANES'(1) << 5;
    tick();
    match_vec = '0;
    chk1("t3_done", done, 1'b1);
    chk1("t3_found", found, 1'b0);

    // Bits 3 and 9 at base 56 -> 59; a later hit at base 84 is ignored
    go(56'd0, 56'd1000);
    run_to(20);
    match_vec = (LANES'(1) << 3) | (LANES'(1) << 9);
    tick();
    match_vec = LANES'(1);
    chkk("t4_fkey", found_key, 56'd59);
    chk1("t4_found", found, 1'b1);
    tick();
    match_vec = '0;
    chkk("t4_fkey_hold", found_key, 56'd59);

    // Top of key space: lanes 10..27 would wrap and must stay masked
    go(kmax - 56'd9, kmax);
    chkk("t5a_base", base_key, kmax - 56'd9);
    tick();
    chk1("t5a_iv_c2", issue_valid, 1'b0);
    run_to(18);
    match_vec = {{(LANES-10){1'b1}}, 10'b0};
    tick();
    match_vec = '0;
    chk1("t5a_done", done, 1'b1);
    chk1("t5a_found", found, 1'b0);
    go(kmax - 56'd9, kmax);
    run_to(18);
    match_vec = LANES'(1) << 9;
    tick();
    match_vec = '0;
    chk1("t5b_found", found, 1'b1);
    chkk("t5b_fkey", found_key, kmax);

    // Abort at cycle 5 (with a simultaneous start: abort wins), late match ignored
    go(56'd0, 56'd1000);
    run_to(5);
    abort  = 1'b1;
    start  = 1'b1;
    key_lo = 56'd500;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_quiet("t6_abort");
    run_to(21);
    match_vec = LANES'(1) << 16;
    tick();
    match_vec = '0;
    chk_quiet("t6_late");
    go(56'd100, 56'd200);
    chkk("t6_base_c1", base_key, 56'd100);
    run_to(19);
    match_vec = LANES'(1) << 2;
    tick();
    match_vec = '0;
    chk1("t6_found", found, 1'b1);
    chkk("t6_fkey", found_key, 56'd130);

    // RESET at cycle 5 abandons the search
    go(56'd0, 56'd1000);
    run_to(5);
    rst = 1'b1;
    #1;
    chk_quiet("t7_rst");
    tick();
    rst = 1'b0;
    run_to(21);
    match_vec = LANES'(1) << 16;
    tick();
    match_vec = '0;
    chk_quiet("t7_late");
    go(56'd0, 56'd55);
    run_to(20);
    chk1("t7_done", done, 1'b1);
    chk1("t7_found", found, 1'b0);

    // Empty range goes straight to DONE with no issue
    go(56'd10, 56'd5);
    chk1("t8_done", done, 1'b1);
    chk1("t8_found", found, 1'b0);
    chk1("t8_iv", issue_valid, 1'b0);
    chk1("t8_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
